pwm_ramp_controller: RTL and testbench
======================================

Name: pwm_ramp_controller

Overview:
- Sequences a single PWMGenerator instance through duty-cycle ramps (fades) toward a commanded target.
- Accepts a command by valid/ready and loads the new period immediately.
- Then steps the duty by a fixed amount every N PWM periods, counting the generator's period_start pulses.
- Drives the generator's update_parameters, pwm_period and pwm_duty_cycle inputs directly.

Parameters:
- WIDTH, 8, width of period/duty/step values; matches the generator's WIDTH.
- IWIDTH, 8, width of the step-interval counter.

Ports:
- clk  input  1  system clock; all logic is posedge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; high only in IDLE.
- cmd_period  input  WIDTH  PWM period for this ramp.
- cmd_duty  input  WIDTH  target duty.
- cmd_step  input  WIDTH  duty increment per step; 0 is treated as 1.
- cmd_interval  input  IWIDTH  PWM periods between steps; 0 is treated as 1.
- abort  input  1  stop the ramp; outputs hold their current values.
- period_start  input  1  one-cycle pulse from the generator at each period start.
- update_parameters  output  1  one-cycle pulse to the generator.
- pwm_period  output  WIDTH  period driven to the generator.
- pwm_duty_cycle  output  WIDTH  duty driven to the generator.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the target is reached.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-ramp):
  - state=IDLE; cmd_ready=1; busy=0; done=0; update_parameters=0.
  - pwm_period=0; pwm_duty_cycle=0; all internal registers 0.
- All outputs are registered.
- States: IDLE, LOAD, WAIT, STEP, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch the command:
    - tgt = min(cmd_duty, cmd_period)
    - stp = max(cmd_step, 1)
    - ivl = max(cmd_interval, 1)
  - Go to LOAD.
- LOAD (1 cycle; outputs visible the cycle after accept):
  - pwm_period <= cmd_period.
  - pwm_duty_cycle <= min(current duty, cmd_period).
  - update_parameters=1.
  - Clear the period counter.
  - Next state: DONE if the loaded duty == tgt, else WAIT.
- WAIT:
  - Each cycle with period_start=1 increments the period counter.
  - When the counter reaches ivl (that counting cycle included), go to STEP.
- STEP (1 cycle):
  - Going up: duty <= (duty+stp >= tgt) ? tgt : duty+stp.
  - Going down: duty <= (duty <= tgt+stp) ? tgt : duty-stp.
  - Compute both with WIDTH+1 bits. The ramp never wraps and never overshoots tgt.
  - update_parameters=1; clear the counter.
  - Next state: DONE if the new duty == tgt, else WAIT.
- DONE (1 cycle): done=1, then IDLE.
- period_start arriving during a LOAD or STEP cycle is not counted.
- update_parameters is high only in LOAD and STEP cycles. It is never high on two consecutive cycles.
- abort:
  - In LOAD, WAIT or STEP: next state is IDLE.
  - No update_parameters or done pulse in that cycle.
  - pwm_period/pwm_duty_cycle hold their last values.
  - abort has priority over period_start, counter expiry and step.
  - Ignored in IDLE and DONE.
- cmd_valid while busy: cmd_ready=0, command not consumed. The requester holds it until IDLE.
- Between ramps, pwm_period/pwm_duty_cycle hold their values. The next command ramps from the held duty.

Test Plan:
1. Reset: assert reset low asynchronously mid-cycle -> all outputs read 0, cmd_ready=1, without waiting for a clk edge.
2. Ramp up: from duty 0, command period=63, duty=40, step=8, interval=2; pulse period_start every 63 clks.
   - LOAD update (period 63, duty 0) lands 1 cycle after accept.
   - Then 5 step updates, one after every 2nd period_start: duty 8,16,24,32,40.
   - done pulses the cycle after the 40 update; exactly 6 update pulses in total.
3. Ramp down with a non-multiple step: from 40, command period=63, duty=5, step=10, interval=1 -> duty 30,20,10,5, then done; no value below 5 ever appears.
4. Clamping, both starting from duty 40:
   - Command period=20, duty=50 -> LOAD drives period 20, duty 20; done next cycle; zero STEP updates.
   - Command step=0, interval=0 -> treated as step 1 after every single period_start.
5. Abort: assert abort in the same cycle that the interval-completing period_start arrives -> no update or done pulse; outputs hold; cmd_ready=1 on the next cycle.
6. Back-pressure:
   - A second cmd_valid during a ramp is not accepted (cmd_ready=0).
   - It is accepted in the first IDLE cycle after done.
   - It ramps from the held duty.

Source files
------------

// File: rtl/pwm_ramp_controller.sv
// Ramps a PWM generator's duty cycle toward a commanded target, one fixed step
// every N generator periods, reloading the period at the start of each ramp.
module pwm_ramp_controller #(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_period,
  input  logic [WIDTH-1:0]  cmd_duty,
  input  logic [WIDTH-1:0]  cmd_step,
  input  logic [IWIDTH-1:0] cmd_interval,
  input  logic              abort,
  input  logic              period_start,
  output logic              update_parameters,
  output logic [WIDTH-1:0]  pwm_period,
  output logic [WIDTH-1:0]  pwm_duty_cycle,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [WIDTH-1:0]  ONE_W = WIDTH'(1);
  localparam logic [IWIDTH-1:0] ONE_I = IWIDTH'(1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  tgt_q, tgt_d;
  logic [WIDTH-1:0]  stp_q, stp_d;
  logic [IWIDTH-1:0] ivl_q, ivl_d;
  logic [IWIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  period_q, period_d;
  logic [WIDTH-1:0]  duty_q, duty_d;
  logic              update_q, update_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic [WIDTH:0]    sum_up;
  logic [WIDTH:0]    lim_dn;
  logic [WIDTH-1:0]  step_duty;
  logic [IWIDTH:0]   cnt_next;

  // Next duty for a step, computed one bit wider so it can neither wrap nor pass the target
  always_comb begin
    sum_up    = {1'b0, duty_q} + {1'b0, stp_q};
    lim_dn    = {1'b0, tgt_q} + {1'b0, stp_q};
    cnt_next  = {1'b0, cnt_q} + {1'b0, ONE_I};
    step_duty = duty_q;
    if (duty_q < tgt_q) begin
      if (sum_up >= {1'b0, tgt_q}) begin
        step_duty = tgt_q;
      end else begin
        step_duty = sum_up[WIDTH-1:0];
      end
    end else begin
      if ({1'b0, duty_q} <= lim_dn) begin
        step_duty = tgt_q;
      end else begin
        step_duty = duty_q - stp_q;
      end
    end
  end

  // State transitions; outputs are computed on entry so they are registered for the state they belong to
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    stp_d    = stp_q;
    ivl_d    = ivl_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    duty_d   = duty_q;
    update_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          tgt_d    = (cmd_duty < cmd_period) ? cmd_duty : cmd_period;
          stp_d    = (cmd_step == '0) ? ONE_W : cmd_step;
          ivl_d    = (cmd_interval == '0) ? ONE_I : cmd_interval;
          period_d = cmd_period;
          duty_d   = (duty_q < cmd_period) ? duty_q : cmd_period;
          update_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD, S_STEP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (duty_q == tgt_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (period_start) begin
          if (cnt_next >= {1'b0, ivl_q}) begin
            duty_d   = step_duty;
            update_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_STEP;
          end else begin
            cnt_d = cnt_next[IWIDTH-1:0];
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      stp_q    <= '0;
      ivl_q    <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      duty_q   <= '0;
      update_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      stp_q    <= stp_d;
      ivl_q    <= ivl_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      update_q <= update_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign cmd_ready         = ready_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign update_parameters = update_q;
  assign pwm_period        = period_q;
  assign pwm_duty_cycle    = duty_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller: ramps, clamping, abort, back-pressure, async reset.
module tb_pwm_ramp_controller;
  localparam int W  = 8;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          abort = 1'b0;
  logic          period_start = 1'b0;
  logic [W-1:0]  cmd_period = '0;
  logic [W-1:0]  cmd_duty = '0;
  logic [W-1:0]  cmd_step = '0;
  logic [IW-1:0] cmd_interval = '0;
  logic          cmd_ready, update_parameters, busy, done;
  logic [W-1:0]  pwm_period, pwm_duty_cycle;

  int n_checks = 0;
  int n_fail = 0;
  int upd_duty[16];
  int upd_per[16];
  int upd_cyc[16];
  int upd_n;
  int done_c;
  bit consec;

  always #5 clk = ~clk;

  pwm_ramp_controller #(.WIDTH(W), .IWIDTH(IW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_duty(cmd_duty), .cmd_step(cmd_step),
    .cmd_interval(cmd_interval), .abort(abort), .period_start(period_start),
    .update_parameters(update_parameters), .pwm_period(pwm_period),
    .pwm_duty_cycle(pwm_duty_cycle), .busy(busy), .done(done)
  );

  // Present a command and hold it until the controller takes it; returns just after the accepting edge.
  task automatic accept_cmd(input int p, input int d, input int s, input int i);
    cmd_period   = W'(p);
    cmd_duty     = W'(d);
    cmd_step     = W'(s);
    cmd_interval = IW'(i);
    cmd_valid    = 1'b1;
    for (int k = 0; k < 20 && !cmd_ready; k++) @(negedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Pulse period_start every 'every' clocks and record update pulses until done or the budget runs out.
  task automatic run_ramp(input int every, input int budget);
    bit prev_upd;
    upd_n = 0; done_c = -1; consec = 0; prev_upd = 0;
    for (int k = 0; k < 16; k++) begin
      upd_duty[k] = -1; upd_per[k] = -1; upd_cyc[k] = -1;
    end
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (update_parameters) begin
        if (prev_upd) consec = 1;
        if (upd_n < 16) begin
          upd_duty[upd_n] = int'(pwm_duty_cycle);
          upd_per[upd_n]  = int'(pwm_period);
          upd_cyc[upd_n]  = c;
        end
        upd_n++;
      end
      prev_upd = update_parameters;
      if (done) begin
        done_c = c;
        break;
      end
      period_start = ((c + 1) % every) == 0;
    end
    period_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || update_parameters !== 1'b0 ||
        pwm_period !== 8'd0 || pwm_duty_cycle !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_init: got ready=%b busy=%b done=%b upd=%b per=%0d duty=%0d required 1 0 0 0 0 0",
               cmd_ready, busy, done, update_parameters, pwm_period, pwm_duty_cycle);
    end
    @(negedge clk) reset = 1'b1;
    accept_cmd(63, 10, 10, 1);
    run_ramp(3, 50);
    n_checks++;
    if (pwm_duty_cycle !== 8'd10 || pwm_period !== 8'd63) begin
      n_fail++;
      $display("FAIL pre_reset_ramp: got per=%0d duty=%0d required 63 10", pwm_period, pwm_duty_cycle);
    end
    accept_cmd(40, 30, 10, 1);
    #2;
    n_checks++;
    if (update_parameters !== 1'b1 || busy !== 1'b1 || pwm_period !== 8'd40) begin
      n_fail++;
      $display("FAIL midramp_load: got upd=%b busy=%b per=%0d required 1 1 40", update_parameters, busy, pwm_period);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || update_parameters !== 1'b0 ||
        pwm_period !== 8'd0 || pwm_duty_cycle !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async: got ready=%b busy=%b done=%b upd=%b per=%0d duty=%0d required 1 0 0 0 0 0",
               cmd_ready, busy, done, update_parameters, pwm_period, pwm_duty_cycle);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_ramp_up();
    int exp_d[6] = '{0, 8, 16, 24, 32, 40};
    accept_cmd(63, 40, 8, 2);
    run_ramp(63, 800);
    n_checks++;
    if (upd_n != 6 || done_c != 631) begin
      n_fail++;
      $display("FAIL up_count: got updates=%0d done_cycle=%0d required 6 631", upd_n, done_c);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (upd_duty[i] != exp_d[i] || upd_per[i] != 63 || upd_cyc[i] != 126 * i) begin
        n_fail++;
        $display("FAIL up_update%0d: got duty=%0d per=%0d cycle=%0d required %0d 63 %0d",
                 i, upd_duty[i], upd_per[i], upd_cyc[i], exp_d[i], 126 * i);
      end
    end
    n_checks++;
    if (consec) begin
      n_fail++;
      $display("FAIL up_consecutive: got back-to-back update pulses required none");
    end
  endtask

  task automatic test_ramp_down();
    int exp_d[5] = '{40, 30, 20, 10, 5};
    int min_d = 255;
    accept_cmd(63, 5, 10, 1);
    run_ramp(63, 400);
    n_checks++;
    if (upd_n != 5 || done_c != 253) begin
      n_fail++;
      $display("FAIL down_count: got updates=%0d done_cycle=%0d required 5 253", upd_n, done_c);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (upd_duty[i] != exp_d[i]) begin
        n_fail++;
        $display("FAIL down_update%0d: got duty=%0d required %0d", i, upd_duty[i], exp_d[i]);
      end
      if (upd_duty[i] >= 0 && upd_duty[i] < min_d) min_d = upd_duty[i];
    end
    n_checks++;
    if (min_d != 5) begin
      n_fail++;
      $display("FAIL down_floor: got minimum duty=%0d required 5", min_d);
    end
  endtask

  task automatic test_no_overshoot();
    accept_cmd(63, 40, 40, 1);
    run_ramp(4, 50);
    n_checks++;
    if (upd_n != 2 || upd_duty[0] != 5 || upd_duty[1] != 40 || done_c != 5) begin
      n_fail++;
      $display("FAIL overshoot: got updates=%0d duty0=%0d duty1=%0d done_cycle=%0d required 2 5 40 5",
               upd_n, upd_duty[0], upd_duty[1], done_c);
    end
  endtask

  task automatic test_step_zero();
    accept_cmd(63, 43, 0, 0);
    run_ramp(4, 60);
    n_checks++;
    if (upd_n != 4 || done_c != 13) begin
      n_fail++;
      $display("FAIL zero_count: got updates=%0d done_cycle=%0d required 4 13", upd_n, done_c);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (upd_duty[i] != 40 + i || upd_cyc[i] != 4 * i) begin
        n_fail++;
        $display("FAIL zero_update%0d: got duty=%0d cycle=%0d required %0d %0d",
                 i, upd_duty[i], upd_cyc[i], 40 + i, 4 * i);
      end
    end
  endtask

  task automatic test_clamp();
    accept_cmd(63, 40, 8, 1);
    run_ramp(4, 50);
    n_checks++;
    if (upd_n != 2 || upd_duty[0] != 43 || upd_duty[1] != 40 || done_c != 5) begin
      n_fail++;
      $display("FAIL clamp_down: got updates=%0d duty0=%0d duty1=%0d done_cycle=%0d required 2 43 40 5",
               upd_n, upd_duty[0], upd_duty[1], done_c);
    end
    accept_cmd(20, 50, 3, 1);
    run_ramp(4, 50);
    n_checks++;
    if (upd_n != 1 || upd_duty[0] != 20 || upd_per[0] != 20 || done_c != 1) begin
      n_fail++;
      $display("FAIL clamp_period: got updates=%0d duty=%0d per=%0d done_cycle=%0d required 1 20 20 1",
               upd_n, upd_duty[0], upd_per[0], done_c);
    end
  endtask

  task automatic test_abort();
    bit late_pulse = 0;
    accept_cmd(63, 60, 5, 2);
    for (int c = 0; c <= 60; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if (update_parameters !== 1'b1 || pwm_duty_cycle !== 8'd20 || pwm_period !== 8'd63) begin
          n_fail++;
          $display("FAIL abort_load: got upd=%b duty=%0d per=%0d required 1 20 63",
                   update_parameters, pwm_duty_cycle, pwm_period);
        end
      end
      if (c == 20) begin
        n_checks++;
        if (update_parameters !== 1'b1 || pwm_duty_cycle !== 8'd25) begin
          n_fail++;
          $display("FAIL abort_step: got upd=%b duty=%0d required 1 25", update_parameters, pwm_duty_cycle);
        end
      end
      if (c == 40) begin
        n_checks++;
        if (update_parameters !== 1'b0 || done !== 1'b0 || pwm_duty_cycle !== 8'd25 ||
            pwm_period !== 8'd63 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_hold: got upd=%b done=%b duty=%0d per=%0d ready=%b busy=%b required 0 0 25 63 1 0",
                   update_parameters, done, pwm_duty_cycle, pwm_period, cmd_ready, busy);
        end
      end
      if (c > 40 && (update_parameters || done)) late_pulse = 1;
      abort        = (c + 1) == 40;
      period_start = ((c + 1) % 10) == 0;
    end
    abort = 1'b0;
    period_start = 1'b0;
    n_checks++;
    if (late_pulse || pwm_duty_cycle !== 8'd25) begin
      n_fail++;
      $display("FAIL abort_after: got late_pulse=%0d duty=%0d required 0 25", late_pulse, pwm_duty_cycle);
    end
  endtask

  task automatic test_back_to_back();
    int exp_d[5] = '{25, 30, 30, 25, 20};
    int exp_p[5] = '{63, 63, 50, 50, 50};
    int exp_c[5] = '{0, 6, 9, 12, 18};
    int acc_c = -1;
    int n_done = 0;
    int last_done = -1;
    int ready_bad = 0;
    upd_n = 0;
    accept_cmd(63, 30, 5, 1);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (update_parameters && upd_n < 16) begin
        upd_duty[upd_n] = int'(pwm_duty_cycle);
        upd_per[upd_n]  = int'(pwm_period);
        upd_cyc[upd_n]  = c;
        upd_n++;
      end
      if (done) begin
        n_done++;
        last_done = c;
      end
      if (c <= 7 && cmd_ready) ready_bad++;
      if (acc_c < 0 && cmd_valid && cmd_ready) acc_c = c;
      else if (acc_c >= 0) cmd_valid = 1'b0;
      if (c == 0) begin
        cmd_period = 8'd50; cmd_duty = 8'd20; cmd_step = 8'd5; cmd_interval = 8'd1;
        cmd_valid = 1'b1;
      end
      if (n_done == 2) break;
      period_start = ((c + 1) % 6) == 0;
    end
    period_start = 1'b0;
    cmd_valid = 1'b0;
    n_checks++;
    if (ready_bad != 0 || acc_c != 8) begin
      n_fail++;
      $display("FAIL b2b_accept: got ready_while_busy=%0d accept_cycle=%0d required 0 8", ready_bad, acc_c);
    end
    n_checks++;
    if (upd_n != 5 || n_done != 2 || last_done != 19) begin
      n_fail++;
      $display("FAIL b2b_count: got updates=%0d dones=%0d last_done=%0d required 5 2 19", upd_n, n_done, last_done);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (upd_duty[i] != exp_d[i] || upd_per[i] != exp_p[i] || upd_cyc[i] != exp_c[i]) begin
        n_fail++;
        $display("FAIL b2b_update%0d: got duty=%0d per=%0d cycle=%0d required %0d %0d %0d",
                 i, upd_duty[i], upd_per[i], upd_cyc[i], exp_d[i], exp_p[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_no_overshoot();
    test_step_zero();
    test_clamp();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
